// File: rtl/aui_pkg.sv
// Shared constants and state type for the AM block scheduler.
package aui_pkg;

  localparam int BITS_BLOCK    = 257;
  localparam int AM_BLOCKS     = 4;
  localparam int MAX_BLOCKS_AM = 40;
  localparam int AM_W          = AM_BLOCKS * BITS_BLOCK;

  typedef enum logic [1:0] {SCH_IDLE, SCH_AM, SCH_DATA} sched_state_t;

endpackage

// File: rtl/am_block_scheduler.sv
// Emits each period's alignment-marker blocks followed by upstream data blocks
// on two 257-bit flows, through a single registered valid/ready output stage.
//
// state    | meaning
// SCH_IDLE | waiting for i_en; output drains
// SCH_AM   | emitting latched AM blocks, LSB block first
// SCH_DATA | passing upstream data blocks until the period is full
module am_block_scheduler #(
  parameter int BITS_BLOCK    = aui_pkg::BITS_BLOCK,
  parameter int AM_BLOCKS     = aui_pkg::AM_BLOCKS,
  parameter int MAX_BLOCKS_AM = aui_pkg::MAX_BLOCKS_AM,
  localparam int AM_W         = AM_BLOCKS * BITS_BLOCK
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic [AM_W-1:0]       i_am_f0,
  input  logic [AM_W-1:0]       i_am_f1,
  input  logic [BITS_BLOCK-1:0] i_data_f0,
  input  logic [BITS_BLOCK-1:0] i_data_f1,
  input  logic                  i_data_valid,
  output logic                  o_data_ready,
  output logic [BITS_BLOCK-1:0] o_flow_0,
  output logic [BITS_BLOCK-1:0] o_flow_1,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_am_flag,
  output logic                  o_sop,
  output logic [15:0]           o_period_cnt,
  output logic                  o_busy
);
  import aui_pkg::*;

  localparam int DATA_BLOCKS = MAX_BLOCKS_AM - AM_BLOCKS;
  localparam int IDX_W = (AM_BLOCKS > 1) ? $clog2(AM_BLOCKS) : 1;
  localparam int CNT_W = (DATA_BLOCKS > 1) ? $clog2(DATA_BLOCKS) : 1;

  sched_state_t     state, state_nxt;
  logic [AM_W-1:0]  am_q0, am_q1;
  logic [IDX_W-1:0] am_idx;
  logic [CNT_W-1:0] blk_cnt;
  logic             ld;
  logic             latch_am, load_am, load_data, clr_valid, blk_clr, blk_inc, period_inc;

  assign ld     = !o_valid || i_ready;
  assign o_busy = (state != SCH_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SCH_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    latch_am     = 1'b0;
    load_am      = 1'b0;
    load_data    = 1'b0;
    clr_valid    = 1'b0;
    blk_clr      = 1'b0;
    blk_inc      = 1'b0;
    period_inc   = 1'b0;
    o_data_ready = 1'b0;
    case (state)
      SCH_IDLE: begin
        clr_valid = ld;
        if (i_en) begin
          latch_am  = 1'b1;
          state_nxt = SCH_AM;
        end
      end
      SCH_AM: begin
        if (ld) begin
          load_am = 1'b1;
          if (am_idx == IDX_W'(AM_BLOCKS - 1)) begin
            blk_clr   = 1'b1;
            state_nxt = SCH_DATA;
          end
        end
      end
      SCH_DATA: begin
        o_data_ready = ld;
        if (ld && i_data_valid) begin
          load_data = 1'b1;
          blk_inc   = 1'b1;
          if (blk_cnt == CNT_W'(DATA_BLOCKS - 1)) begin
            period_inc = 1'b1;
            blk_clr    = 1'b1;
            // Re-latch at the boundary so the next AM follows with no bubble.
            if (i_en) begin
              latch_am  = 1'b1;
              state_nxt = SCH_AM;
            end else begin
              state_nxt = SCH_IDLE;
            end
          end
        end else if (ld) begin
          clr_valid = 1'b1;
        end
      end
      default: state_nxt = SCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      am_q0        <= '0;
      am_q1        <= '0;
      am_idx       <= '0;
      blk_cnt      <= '0;
      o_period_cnt <= '0;
      o_flow_0     <= '0;
      o_flow_1     <= '0;
      o_valid      <= 1'b0;
      o_am_flag    <= 1'b0;
      o_sop        <= 1'b0;
    end else begin
      if (latch_am) begin
        am_q0  <= i_am_f0;
        am_q1  <= i_am_f1;
        am_idx <= '0;
      end else if (load_am) begin
        am_idx <= am_idx + IDX_W'(1);
      end
      if (blk_clr)      blk_cnt <= '0;
      else if (blk_inc) blk_cnt <= blk_cnt + CNT_W'(1);
      if (period_inc) o_period_cnt <= o_period_cnt + 16'd1;
      if (load_am) begin
        o_flow_0  <= am_q0[int'(am_idx)*BITS_BLOCK +: BITS_BLOCK];
        o_flow_1  <= am_q1[int'(am_idx)*BITS_BLOCK +: BITS_BLOCK];
        o_valid   <= 1'b1;
        o_am_flag <= 1'b1;
        o_sop     <= (am_idx == '0);
      end else if (load_data) begin
        o_flow_0  <= i_data_f0;
        o_flow_1  <= i_data_f1;
        o_valid   <= 1'b1;
        o_am_flag <= 1'b0;
        o_sop     <= 1'b0;
      end else if (clr_valid) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_am_block_scheduler.sv
// Table-driven bench for am_block_scheduler: scenario rows stream against a
// scoreboard queue, plus hand-written asynchronous reset sequences.
module tb_am_block_scheduler;
  import aui_pkg::*;

  localparam int DB = MAX_BLOCKS_AM - AM_BLOCKS;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  i_en;
  logic [AM_W-1:0]       i_am_f0, i_am_f1;
  logic [BITS_BLOCK-1:0] i_data_f0, i_data_f1;
  logic                  i_data_valid;
  logic                  o_data_ready;
  logic [BITS_BLOCK-1:0] o_flow_0, o_flow_1;
  logic                  o_valid;
  logic                  i_ready;
  logic                  o_am_flag, o_sop;
  logic [15:0]           o_period_cnt;
  logic                  o_busy;

  am_block_scheduler dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_am_f0(i_am_f0), .i_am_f1(i_am_f1),
    .i_data_f0(i_data_f0), .i_data_f1(i_data_f1), .i_data_valid(i_data_valid),
    .o_data_ready(o_data_ready), .o_flow_0(o_flow_0), .o_flow_1(o_flow_1),
    .o_valid(o_valid), .i_ready(i_ready), .o_am_flag(o_am_flag), .o_sop(o_sop),
    .o_period_cnt(o_period_cnt), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    ready_pct;
    int    valid_pct;
    int    periods;
    bit    en_drop;
    int    exp_outputs;
    int    exp_periods;
  } row_t;

  int errors = 0;
  int checks = 0;

  logic [BITS_BLOCK-1:0] exp_f0[$], exp_f1[$];
  bit                    exp_flag[$], exp_sop[$];
  logic [AM_W-1:0]       am0_ok, am1_ok;

  task automatic chk(input string nm, input logic [BITS_BLOCK-1:0] act, input logic [BITS_BLOCK-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic logic [BITS_BLOCK-1:0] dat(input int k, input int flow);
    if (flow != 0) return BITS_BLOCK'(k) | (BITS_BLOCK'(1) << (BITS_BLOCK - 1));
    return BITS_BLOCK'(k + 1000);
  endfunction

  // Block n of flow 0 is n+1 (flow 1: n+17), with a row tag in the upper bits.
  function automatic logic [AM_W-1:0] make_am(input int r, input int flow);
    logic [AM_W-1:0] v;
    v = '0;
    for (int n = 0; n < AM_BLOCKS; n++)
      v[n*BITS_BLOCK +: BITS_BLOCK] = BITS_BLOCK'(n + 1 + 16*flow) | (BITS_BLOCK'(r) << 128);
    if (flow != 0) v[AM_W-1 -: 3] = 3'b111;
    return v;
  endfunction

  task automatic check_reset_zero(input string nm);
    chk(nm, BITS_BLOCK'({o_valid, o_am_flag, o_sop, o_busy, o_data_ready, o_period_cnt,
                         |o_flow_0, |o_flow_1}), '0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_zero("reset_state");
    rst = 1'b0;
  endtask

  task automatic run_row(input row_t r, input int ri);
    int in_cnt, out_cnt, cyc, first_cyc, last_cyc, next_load;
    bit stalled;
    logic [BITS_BLOCK-1:0] s0, s1;
    logic sf, ss;
    in_cnt = 0; out_cnt = 0; cyc = 0; first_cyc = -1; last_cyc = 0; stalled = 1'b0;
    s0 = '0; s1 = '0; sf = 1'b0; ss = 1'b0;
    am0_ok = make_am(ri, 0);
    am1_ok = make_am(ri, 1);
    exp_f0.delete(); exp_f1.delete(); exp_flag.delete(); exp_sop.delete();
    for (int p = 0; p < r.periods; p++) begin
      for (int n = 0; n < AM_BLOCKS; n++) begin
        exp_f0.push_back(am0_ok[n*BITS_BLOCK +: BITS_BLOCK]);
        exp_f1.push_back(am1_ok[n*BITS_BLOCK +: BITS_BLOCK]);
        exp_flag.push_back(1'b1);
        exp_sop.push_back(n == 0);
      end
      for (int j = 0; j < DB; j++) begin
        exp_f0.push_back(dat(p*DB + j, 0));
        exp_f1.push_back(dat(p*DB + j, 1));
        exp_flag.push_back(1'b0);
        exp_sop.push_back(1'b0);
      end
    end
    i_en = 1'b1; i_am_f0 = am0_ok; i_am_f1 = am1_ok;
    i_ready = 1'b1; i_data_valid = 1'b0;
    apply_reset();
    while (out_cnt < r.exp_outputs && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        chk({r.name, " hold_f0"}, o_flow_0, s0);
        chk({r.name, " hold_f1"}, o_flow_1, s1);
        chk({r.name, " hold_flags"}, BITS_BLOCK'({o_valid, o_am_flag, o_sop}), BITS_BLOCK'({1'b1, sf, ss}));
      end
      i_ready      = (int'($urandom_range(99)) < r.ready_pct);
      i_data_valid = (int'($urandom_range(99)) < r.valid_pct);
      i_data_f0    = dat(in_cnt, 0);
      i_data_f1    = dat(in_cnt, 1);
      i_en         = !(r.en_drop && in_cnt >= (r.periods - 1)*DB + 10);
      if (in_cnt % DB >= 5 && in_cnt % DB <= 20) begin
        i_am_f0 = ~am0_ok;
        i_am_f1 = ~am1_ok;
      end else begin
        i_am_f0 = am0_ok;
        i_am_f1 = am1_ok;
      end
      #1;
      next_load = out_cnt + int'(o_valid);
      if (next_load < r.exp_outputs) begin
        if (exp_flag[next_load]) chk({r.name, " ready_in_am"}, BITS_BLOCK'(o_data_ready), '0);
        else chk({r.name, " ready_in_data"}, BITS_BLOCK'(o_data_ready), BITS_BLOCK'(!o_valid || i_ready));
      end
      if (o_valid && i_ready) begin
        chk($sformatf("%s out%0d_f0", r.name, out_cnt), o_flow_0, exp_f0[out_cnt]);
        chk($sformatf("%s out%0d_f1", r.name, out_cnt), o_flow_1, exp_f1[out_cnt]);
        chk($sformatf("%s out%0d_flags", r.name, out_cnt), BITS_BLOCK'({o_am_flag, o_sop}),
            BITS_BLOCK'({exp_flag[out_cnt], exp_sop[out_cnt]}));
        if (ri == 0 && out_cnt < AM_BLOCKS)
          chk($sformatf("am_slice_%0d", out_cnt), o_flow_0, BITS_BLOCK'(out_cnt + 1));
        if (ri == 0 && out_cnt == AM_BLOCKS - 1)
          chk("am_f1_status", BITS_BLOCK'(o_flow_1[BITS_BLOCK-1 -: 3]), BITS_BLOCK'(3'b111));
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        out_cnt++;
      end
      if (i_data_valid && o_data_ready) in_cnt++;
      stalled = o_valid && !i_ready;
      s0 = o_flow_0; s1 = o_flow_1; sf = o_am_flag; ss = o_sop;
    end
    checks++;
    if (out_cnt < r.exp_outputs) begin
      errors++;
      $display("FAIL %s timeout: got %0d outputs expected %0d", r.name, out_cnt, r.exp_outputs);
    end
    @(negedge clk);
    chk({r.name, " period_cnt"}, BITS_BLOCK'(o_period_cnt), BITS_BLOCK'(r.exp_periods));
    chk({r.name, " accepted"}, BITS_BLOCK'(in_cnt), BITS_BLOCK'(r.periods * DB));
    if (r.ready_pct == 100 && r.valid_pct == 100)
      chk({r.name, " no_gap"}, BITS_BLOCK'(last_cyc - first_cyc), BITS_BLOCK'(r.exp_outputs - 1));
    if (r.en_drop) begin
      i_ready = 1'b1;
      i_data_valid = 1'b1;
      repeat (4) begin
        @(negedge clk);
        chk({r.name, " idle_after"}, BITS_BLOCK'({o_valid, o_busy, o_data_ready}), '0);
      end
      chk({r.name, " period_cnt_hold"}, BITS_BLOCK'(o_period_cnt), BITS_BLOCK'(r.exp_periods));
    end
  endtask

  task automatic wait_out(input string nm, input logic [BITS_BLOCK-1:0] f0, input bit am, input int pcnt);
    int n;
    n = 0;
    while (!(o_valid && o_am_flag == am && o_flow_0 == f0 && int'(o_period_cnt) == pcnt) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s timeout: got no matching output expected flow0 %0h", nm, f0);
    end
  endtask

  task automatic reset_seq();
    am0_ok = make_am(0, 0);
    am1_ok = make_am(0, 1);
    i_am_f0 = am0_ok; i_am_f1 = am1_ok;
    i_en = 1'b1; i_ready = 1'b1; i_data_valid = 1'b1;
    i_data_f0 = dat(7, 0); i_data_f1 = dat(7, 1);
    apply_reset();
    // Block value 2 on the output means am_idx has advanced to 2.
    wait_out("mid_am", BITS_BLOCK'(2), 1'b1, 0);
    #2 rst = 1'b1;
    #1 check_reset_zero("async_rst_am");
    @(negedge clk);
    rst = 1'b0;
    wait_out("restart_am", BITS_BLOCK'(1), 1'b1, 0);
    chk("restart_am_sop", BITS_BLOCK'(o_sop), BITS_BLOCK'(1));
    wait_out("mid_data", dat(7, 0), 1'b0, 1);
    #2 rst = 1'b1;
    #1 check_reset_zero("async_rst_data");
    @(negedge clk);
    rst = 1'b0;
    wait_out("restart_data", BITS_BLOCK'(1), 1'b1, 0);
    chk("restart_data_sop", BITS_BLOCK'({o_sop, o_period_cnt}), BITS_BLOCK'({1'b1, 16'd0}));
  endtask

  initial begin
    row_t rows[5];
    rst = 1'b1; i_en = 1'b0; i_ready = 1'b0; i_data_valid = 1'b0;
    i_am_f0 = '0; i_am_f1 = '0; i_data_f0 = '0; i_data_f1 = '0;
    rows[0] = '{name: "basic",    ready_pct: 100, valid_pct: 100, periods: 2, en_drop: 1'b0, exp_outputs: 80,  exp_periods: 2};
    rows[1] = '{name: "backpres", ready_pct: 50,  valid_pct: 100, periods: 3, en_drop: 1'b0, exp_outputs: 120, exp_periods: 3};
    rows[2] = '{name: "gaps",     ready_pct: 100, valid_pct: 50,  periods: 2, en_drop: 1'b0, exp_outputs: 80,  exp_periods: 2};
    rows[3] = '{name: "en_drop",  ready_pct: 100, valid_pct: 100, periods: 1, en_drop: 1'b1, exp_outputs: 40,  exp_periods: 1};
    rows[4] = '{name: "mixed",    ready_pct: 60,  valid_pct: 60,  periods: 2, en_drop: 1'b1, exp_outputs: 80,  exp_periods: 2};
    for (int i = 0; i < 5; i++) run_row(rows[i], i);
    reset_seq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
